// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver.
// Scans NUM_DIGITS common-anode digits, one slot of REFRESH_DIV cycles each.
// Each slot opens with one dark cycle to avoid ghosting. Digits can be blanked
// or made to blink, and the blink rate is counted in whole scan frames.
// load is a plain capture strobe with no handshake: on every clk edge where
// load=1, digit_data, blank_mask and blink_mask are copied into shadow
// registers. The display reads only those shadows.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_tick
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [FRM_W-1:0]        frm_cnt;
  logic                    blink_phase;
  logic [4*NUM_DIGITS-1:0] digit_sh;
  logic [NUM_DIGITS-1:0]   blank_sh;
  logic [NUM_DIGITS-1:0]   blink_sh;

  logic                    slot_end;
  logic                    frame_end;
  logic [3:0]              cur_nib;
  logic                    cur_blank;
  logic                    cur_blink;
  logic                    digit_off;
  logic [NUM_DIGITS-1:0]   sel_low;
  logic [6:0]              seg_nxt;
  logic [NUM_DIGITS-1:0]   anode_nxt;

  // Hex nibble to gfedcba pattern, active-low.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Slot and frame boundary decode.
  always_comb begin
    slot_end  = (cnt == CNT_LAST);
    frame_end = slot_end && (idx == IDX_LAST);
  end

  // Pick the active digit's shadow content and its one-hot anode.
  always_comb begin
    cur_nib   = 4'h0;
    cur_blank = 1'b0;
    cur_blink = 1'b0;
    sel_low   = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib    = digit_sh[4*i +: 4];
        cur_blank  = blank_sh[i];
        cur_blink  = blink_sh[i];
        sel_low[i] = 1'b0;
      end
    end
  end

  // Next output values: dark at slot start or when the digit is off.
  always_comb begin
    digit_off = cur_blank | (cur_blink & blink_phase);
    seg_nxt   = 7'b1111111;
    anode_nxt = '1;
    if ((cnt != '0) && !digit_off) begin
      seg_nxt   = hex7(cur_nib);
      anode_nxt = sel_low;
    end
  end

  // Prescaler and digit index; load never touches these.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Frame counter and blink phase, advanced once per completed frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      frm_cnt     <= '0;
      blink_phase <= 1'b0;
    end else if (frame_end) begin
      if (frm_cnt == FRM_LAST) begin
        frm_cnt     <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frm_cnt <= frm_cnt + 1'b1;
      end
    end
  end

  // Shadow registers; reset leaves every digit blanked.
  always_ff @(posedge clk) begin
    if (reset) begin
      digit_sh <= '0;
      blank_sh <= '1;
      blink_sh <= '0;
    end else if (load) begin
      digit_sh <= digit_data;
      blank_sh <= blank_mask;
      blink_sh <= blink_mask;
    end
  end

  // Registered outputs, one cycle behind the scan state.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg        <= 7'b1111111;
      anode      <= '1;
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_nxt;
      anode      <= anode_nxt;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with NUM_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2.
// The driver pushes the expected {seg, anode, frame_tick} for every edge.
// The monitor pops and compares that value just after the edge.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] digit_data;
  logic [3:0]  blank_mask;
  logic [3:0]  blink_mask;
  logic [6:0]  seg;
  logic [3:0]  anode;
  logic        frame_tick;

  logic [11:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  // Reference state: steps since the last reset, and the loaded content.
  int          m_s = 0;
  logic [15:0] m_digit = '0;
  logic [3:0]  m_blank = 4'hF;
  logic [3:0]  m_blink = '0;

  seg7_scan_driver #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4),
    .BLINK_FRAMES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .digit_data(digit_data),
    .blank_mask(blank_mask),
    .blink_mask(blink_mask),
    .seg       (seg),
    .anode     (anode),
    .frame_tick(frame_tick)
  );

  // Clock.
  always #5 clk = ~clk;

  function automatic logic [6:0] hex_pat(input logic [3:0] n);
    case (n)
      4'h0: hex_pat = 7'b1000000;
      4'h1: hex_pat = 7'b1111001;
      4'h2: hex_pat = 7'b0100100;
      4'h3: hex_pat = 7'b0110000;
      4'h4: hex_pat = 7'b0011001;
      4'h5: hex_pat = 7'b0010010;
      4'h6: hex_pat = 7'b0000010;
      4'h7: hex_pat = 7'b1111000;
      4'h8: hex_pat = 7'b0000000;
      4'h9: hex_pat = 7'b0010000;
      4'hA: hex_pat = 7'b0001000;
      4'hB: hex_pat = 7'b0000011;
      4'hC: hex_pat = 7'b1000110;
      4'hD: hex_pat = 7'b0100001;
      4'hE: hex_pat = 7'b0000110;
      default: hex_pat = 7'b0001110;
    endcase
  endfunction

  // Expected output after the coming edge, from step number and loaded content.
  // Slot = 4 steps, frame = 16 steps, blink half-period = 2 frames = 32 steps.
  function automatic logic [11:0] expect_out(input logic r);
    int   slot_pos;
    int   dig;
    logic phase;
    logic ft;
    logic off;
    logic [3:0] an;
    if (r) return {7'b1111111, 4'b1111, 1'b0};
    slot_pos = m_s % 4;
    dig      = (m_s / 4) % 4;
    phase    = ((m_s / 32) % 2) == 1;
    ft       = (m_s % 16) == 15;
    off      = m_blank[dig] | (m_blink[dig] & phase);
    if (slot_pos == 0 || off) return {7'b1111111, 4'b1111, ft};
    an = 4'b1111;
    an[dig] = 1'b0;
    return {hex_pat(m_digit[4*dig +: 4]), an, ft};
  endfunction

  // One cycle of stimulus. The expectation is pushed before the edge that samples it.
  task automatic drive(input logic r, input logic l, input logic [15:0] d,
                       input logic [3:0] bm, input logic [3:0] km);
    reset      = r;
    load       = l;
    digit_data = d;
    blank_mask = bm;
    blink_mask = km;
    exp_q.push_back(expect_out(r));
    if (r) begin
      m_s     = 0;
      m_digit = '0;
      m_blank = 4'hF;
      m_blink = '0;
    end else begin
      m_s = m_s + 1;
      if (l) begin
        m_digit = d;
        m_blank = bm;
        m_blink = km;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'hDEAD, 4'hA, 4'h5);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] bm, input logic [3:0] km);
    drive(1'b0, 1'b1, d, bm, km);
  endtask

  // Idle until the next edge samples frame position pos (0..15).
  task automatic run_until(input int pos);
    for (int i = 0; i < 16; i++) begin
      if ((m_s % 16) == pos) break;
      drive(1'b0, 1'b0, 16'h0000, 4'h0, 4'h0);
    end
  endtask

  // Monitor: compare every edge's outputs against the queued expectation.
  initial begin
    logic [11:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({seg, anode, frame_tick} !== e) begin
          n_err++;
          $display("FAIL out_check t=%0t actual seg=%b anode=%b tick=%b required seg=%b anode=%b tick=%b",
                   $time, seg, anode, frame_tick, e[11:5], e[4:1], e[0]);
        end
      end
    end
  end

  // Stimulus sequence and final report.
  initial begin
    int waited;
    // Reset, then 40 idle cycles: everything stays dark (blank shadow all ones).
    drive(1'b1, 1'b1, 16'hFFFF, 4'h0, 4'h0);
    idle(40);
    // Plain scan of 0x1234.
    do_load(16'h1234, 4'b0000, 4'b0000);
    idle(40);
    // Blank digit 2.
    do_load(16'h1234, 4'b0100, 4'b0000);
    idle(36);
    // Blink digit 0 over several half-periods.
    do_load(16'h1234, 4'b0000, 4'b0001);
    idle(140);
    // Mid-slot load at the second lit cycle of digit 0.
    run_until(2);
    do_load(16'hFFFF, 4'b0000, 4'b0000);
    idle(20);
    // Load on the last cycle of a slot: the next slot shows the new value.
    run_until(3);
    do_load(16'h8C0E, 4'b0000, 4'b0000);
    idle(20);
    // Reset during digit 2, then all dark until the next load.
    run_until(9);
    drive(1'b1, 1'b0, 16'h0000, 4'h0, 4'h0);
    drive(1'b1, 1'b1, 16'h7777, 4'h0, 4'h0);
    idle(30);
    do_load(16'h5A3C, 4'b0000, 4'b0000);
    idle(40);
    // Drain the scoreboard within a bounded number of cycles.
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain actual pending=%0d required pending=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: digits scanned; legal 1..8.
REQ-002 SHALL have parameter REFRESH_DIV, default 50000: clock cycles per digit slot; legal >= 2.
REQ-003 SHALL have parameter BLINK_FRAMES, default 64: full scan frames per blink half-period; legal >= 1.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port load  input  1  capture strobe for digit_data, blank_mask and blink_mask.
REQ-007 SHALL have port digit_data  input  4*NUM_DIGITS  hex nibble per digit; digit i = bits [4i+3:4i].
REQ-008 SHALL have port blank_mask  input  NUM_DIGITS  bit i = 1 forces digit i dark.
REQ-009 SHALL have port blink_mask  input  NUM_DIGITS  bit i = 1 makes digit i blink.
REQ-010 SHALL have port seg  output  7  segments gfedcba, active-low, registered.
REQ-011 SHALL have port anode  output  NUM_DIGITS  digit enables, active-low, registered; bit i drives digit i.
REQ-012 SHALL have port frame_tick  output  1  one-cycle pulse per completed scan frame, registered.

Function
REQ-013 SHALL capture digit_data, blank_mask and blink_mask into shadow registers on every clk edge where load=1; displayed content SHALL come only from the shadow registers.
REQ-014 SHALL keep prescaler cnt (0..REFRESH_DIV-1) and digit index idx (0..NUM_DIGITS-1): cnt increments each cycle; at cnt=REFRESH_DIV-1, cnt goes to 0 and idx increments, wrapping NUM_DIGITS-1 -> 0.
REQ-015 SHALL, with NUM_DIGITS=1, hold idx at 0 and still run cnt and frame_tick.
REQ-016 SHALL register outputs from the current-cycle cnt, idx, shadow data and blink phase, giving exactly one cycle of latency.
REQ-017 SHALL drive anode all-ones and seg=1111111 when cnt=0, giving one dead-time cycle at the start of each slot to prevent ghosting.
REQ-018 SHALL, when cnt!=0, drive anode with only bit idx low and seg = hex pattern of nibble idx, unless digit idx is off.
REQ-019 SHALL treat digit idx as off when its shadow blank bit is 1, or when its shadow blink bit is 1 and blink_phase=1; an off digit gives anode all-ones and seg=1111111.
REQ-020 SHALL use hex patterns 0..F: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
REQ-021 SHALL define end-of-frame as cnt=REFRESH_DIV-1 and idx=NUM_DIGITS-1; frame_tick SHALL be 1 for exactly the cycle after each end-of-frame.
REQ-022 SHALL count end-of-frame events in a frame counter (0..BLINK_FRAMES-1); at its terminal count it returns to 0 and blink_phase toggles.
REQ-023 SHALL, when load coincides with a slot change, show the newly loaded value in the new slot; a load mid-slot SHALL affect seg from the second cycle after the strobe.
REQ-024 SHALL NOT let load disturb cnt, idx, the frame counter or blink_phase.

Reset
REQ-025 SHALL, on the clock edge with reset=1, clear cnt, idx, the frame counter, blink_phase, digit shadow (all 0) and blink shadow (all 0), and set blank shadow to all ones.
REQ-026 SHALL hold seg=1111111, anode all-ones and frame_tick=0 during reset and on the first cycle after its release.
REQ-027 SHALL take priority over load on the same edge; reset mid-slot SHALL restart scanning at digit 0, cnt 0.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2)
REQ-028 SHALL check reset: reset 1 cycle, no load -> seg=1111111, anode=1111 and frame_tick=0 for 40 cycles.
REQ-029 SHALL check the scan pattern: load 0x1234 with masks 0 -> each 4-cycle slot = 1 dark cycle then 3 cycles of digit 0 seg=0011001 anode=1110; digit 3 slot gives seg=1111001 anode=0111; frame_tick every 16 cycles.
REQ-030 SHALL check blanking: blank_mask=0100 -> digit 2 slot all dark; other digits unchanged.
REQ-031 SHALL check blinking: blink_mask=0001 -> digit 0 lit for 2 frames, dark for 2 frames, repeating; other digits always lit.
REQ-032 SHALL check a mid-slot load: load 0xFFFF at the second lit cycle of digit 0 -> seg=0001110 from the second cycle after the strobe; cnt and idx timing unchanged.
REQ-033 SHALL check reset mid-scan: reset during digit 2 -> dark outputs, then scan restarts at digit 0 with a dark cycle, and blank shadow = 1111 keeps all digits dark until the next load.
